// File: rtl/predictor_pkg.sv
// Shared definitions for the alpha-beta tracking predictor: phase-state encoding
// and default datapath width and gain shifts.
package predictor_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int ALPHA_SH_DEF = 1;
   localparam int BETA_SH_DEF  = 2;

   typedef enum logic [1:0] {
      WAIT_LATCH   = 2'd0,
      WAIT_UPDATE  = 2'd1,
      WAIT_PREDICT = 2'd2,
      WAIT_OUTPUT  = 2'd3
   } state_e;

endpackage : predictor_pkg

// File: rtl/alpha_beta_predictor_sat_clamp.sv
// Clamps a signed value carrying two guard bits into the signed DATA_W range.
module sat_clamp #(
   parameter int DATA_W = 16
) (
   input  logic signed [DATA_W+1:0] din_i,
   output logic signed [DATA_W-1:0] dout_o
);

   logic [2:0] top_bits;

   assign top_bits = din_i[DATA_W+1:DATA_W-1];

   // NOTE: every path assigns dout_o, so this stays purely combinational (no latch).
   always_comb begin
      dout_o = din_i[DATA_W-1:0];
      if (top_bits != 3'b000 && top_bits != 3'b111) begin
         // Guard bits disagree with the result sign: out of range, pick the rail.
         dout_o = din_i[DATA_W+1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

endmodule : sat_clamp

// File: rtl/alpha_beta_predictor.sv
// Alpha-beta position/velocity tracker driven by four external phase strobes
// (latch, update, predict, output) with sequence checking.
module alpha_beta_predictor
   import predictor_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ALPHA_SH = ALPHA_SH_DEF,
   parameter int BETA_SH  = BETA_SH_DEF
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     latch_trigger,
   input  logic                     update_trigger,
   input  logic                     predict_trigger,
   input  logic                     output_trigger,
   input  logic signed [DATA_W-1:0] measurement,
   output logic signed [DATA_W-1:0] prediction,
   output logic                     prediction_valid,
   output logic                     sequence_error
);

   state_e                   state_q;
   logic signed [DATA_W-1:0] meas_q, x_est_q, v_est_q, x_pred_q, v_pred_q, prediction_q;
   logic                     valid_q, error_q, rep_ok_q, first_q;

   logic signed [DATA_W-1:0] x_est_d, v_est_d, x_pred_d;
   logic signed [DATA_W:0]   resid, resid_a, resid_b;
   logic signed [DATA_W+1:0] x_upd_w, v_upd_w, x_prd_w;
   logic [3:0]               trig;
   logic                     multi_trig;

   assign trig       = {latch_trigger, update_trigger, predict_trigger, output_trigger};
   assign multi_trig = $countones(trig) > 1;

   // Residual carries one extra bit so meas - x_pred can never wrap.
   assign resid   = $signed({meas_q[DATA_W-1], meas_q}) - $signed({x_pred_q[DATA_W-1], x_pred_q});
   assign resid_a = resid >>> ALPHA_SH;
   assign resid_b = resid >>> BETA_SH;

   assign x_upd_w = $signed({{2{x_pred_q[DATA_W-1]}}, x_pred_q}) + $signed({resid_a[DATA_W], resid_a});
   assign v_upd_w = $signed({{2{v_pred_q[DATA_W-1]}}, v_pred_q}) + $signed({resid_b[DATA_W], resid_b});
   assign x_prd_w = $signed({{2{x_est_q[DATA_W-1]}}, x_est_q}) + $signed({{2{v_est_q[DATA_W-1]}}, v_est_q});

   sat_clamp #(.DATA_W(DATA_W)) u_sat_x_est  (.din_i(x_upd_w), .dout_o(x_est_d));
   sat_clamp #(.DATA_W(DATA_W)) u_sat_v_est  (.din_i(v_upd_w), .dout_o(v_est_d));
   sat_clamp #(.DATA_W(DATA_W)) u_sat_x_pred (.din_i(x_prd_w), .dout_o(x_pred_d));

   // NOTE: non-blocking assignments only, so every branch reads pre-edge register values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= WAIT_LATCH;
         meas_q       <= '0;
         x_est_q      <= '0;
         v_est_q      <= '0;
         x_pred_q     <= '0;
         v_pred_q     <= '0;
         prediction_q <= '0;
         valid_q      <= 1'b0;
         error_q      <= 1'b0;
         rep_ok_q     <= 1'b0;
         first_q      <= 1'b1;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         if (multi_trig) begin
            error_q  <= 1'b1;
            rep_ok_q <= 1'b0;
            state_q  <= WAIT_LATCH;
         end else if (latch_trigger && state_q == WAIT_LATCH) begin
            meas_q  <= measurement;
            state_q <= WAIT_UPDATE;
         end else if (update_trigger && state_q == WAIT_UPDATE) begin
            if (first_q) begin
               x_est_q <= meas_q;
               v_est_q <= '0;
               first_q <= 1'b0;
            end else begin
               x_est_q <= x_est_d;
               v_est_q <= v_est_d;
            end
            state_q <= WAIT_PREDICT;
         end else if (predict_trigger && state_q == WAIT_PREDICT) begin
            x_pred_q <= x_pred_d;
            v_pred_q <= v_est_q;
            state_q  <= WAIT_OUTPUT;
         end else if (output_trigger && state_q == WAIT_OUTPUT) begin
            prediction_q <= x_pred_q;
            valid_q      <= 1'b1;
            rep_ok_q     <= 1'b1;
            state_q      <= WAIT_LATCH;
         end else if (output_trigger && state_q == WAIT_LATCH && rep_ok_q) begin
            valid_q  <= 1'b1;
            rep_ok_q <= 1'b0;
         end else if (|trig) begin
            error_q  <= 1'b1;
            rep_ok_q <= 1'b0;
            state_q  <= WAIT_LATCH;
         end
      end
   end

   assign prediction       = prediction_q;
   assign prediction_valid = valid_q;
   assign sequence_error   = error_q;

endmodule : alpha_beta_predictor

// File: tb/tb_alpha_beta_predictor.sv
// Directed bench for alpha_beta_predictor: hand-computed tracking, saturation,
// sequence-error, repeated-output and mid-sequence reset cases.
module tb_alpha_beta_predictor;
   import predictor_pkg::*;

   localparam logic [3:0] T_N = 4'b0000;
   localparam logic [3:0] T_L = 4'b1000;
   localparam logic [3:0] T_U = 4'b0100;
   localparam logic [3:0] T_P = 4'b0010;
   localparam logic [3:0] T_O = 4'b0001;

   logic               clock;
   logic               reset;
   logic               latch_trigger, update_trigger, predict_trigger, output_trigger;
   logic signed [15:0] measurement;
   logic signed [15:0] prediction;
   logic               prediction_valid;
   logic               sequence_error;

   int checks   = 0;
   int failures = 0;

   alpha_beta_predictor dut (
      .clock            (clock),
      .reset            (reset),
      .latch_trigger    (latch_trigger),
      .update_trigger   (update_trigger),
      .predict_trigger  (predict_trigger),
      .output_trigger   (output_trigger),
      .measurement      (measurement),
      .prediction       (prediction),
      .prediction_valid (prediction_valid),
      .sequence_error   (sequence_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock with the given strobes; checks the pulse outputs produced by that edge.
   task automatic step(input logic [3:0] trig, input logic signed [15:0] meas,
                       input logic exp_v, input logic exp_e, input string tag);
      @(negedge clock);
      {latch_trigger, update_trigger, predict_trigger, output_trigger} = trig;
      measurement = meas;
      @(posedge clock);
      #1;
      {latch_trigger, update_trigger, predict_trigger, output_trigger} = T_N;
      check({tag, "_valid"}, 32'(prediction_valid), 32'(exp_v));
      check({tag, "_err"},   32'(sequence_error),   32'(exp_e));
   endtask

   task automatic full_seq(input logic signed [15:0] meas, input logic signed [15:0] exp_pred,
                           input string tag);
      step(T_L, meas, 1'b0, 1'b0, {tag, "_latch"});
      step(T_U, '0,   1'b0, 1'b0, {tag, "_update"});
      step(T_P, '0,   1'b0, 1'b0, {tag, "_predict"});
      step(T_O, '0,   1'b1, 1'b0, {tag, "_output"});
      check({tag, "_pred"}, 32'(prediction), 32'(exp_pred));
   endtask

   task automatic apply_reset(input logic [3:0] trig);
      @(negedge clock);
      reset = 1'b1;
      {latch_trigger, update_trigger, predict_trigger, output_trigger} = trig;
      @(posedge clock);
      #1;
      check("rst_pred",  32'(prediction),       32'sd0);
      check("rst_valid", 32'(prediction_valid), 32'sd0);
      check("rst_err",   32'(sequence_error),   32'sd0);
      @(negedge clock);
      reset = 1'b0;
      {latch_trigger, update_trigger, predict_trigger, output_trigger} = T_N;
   endtask

   initial begin
      reset = 1'b1;
      {latch_trigger, update_trigger, predict_trigger, output_trigger} = T_N;
      measurement = '0;

      // Power-on reset, held for two edges.
      @(posedge clock);
      apply_reset(T_N);

      // First measurement initialises the track directly.
      full_seq(16'sd100, 16'sd100, "first");
      step(T_N, '0, 1'b0, 1'b0, "idle");
      check("idle_pred", 32'(prediction), 32'sd100);

      // r = 20: x_est = 110, v_est = 5, prediction = 115.
      full_seq(16'sd120, 16'sd115, "track");
      check("track_x_est", 32'(dut.x_est_q), 32'sd110);
      check("track_v_est", 32'(dut.v_est_q), 32'sd5);

      // Illegal strobes: update while waiting for latch, then two strobes at once.
      step(T_U,       '0,       1'b0, 1'b1, "bad_update");
      step(T_L | T_U, 16'sd999, 1'b0, 1'b1, "bad_multi");
      check("bad_state", 32'(dut.state_q), 32'(WAIT_LATCH));
      check("bad_pred",  32'(prediction),  32'sd115);

      // r = 0 from (115, 5): prediction 120, then repeated output and a third one.
      full_seq(16'sd115, 16'sd120, "rep");
      step(T_O, '0, 1'b1, 1'b0, "rep_second");
      check("rep_second_pred", 32'(prediction), 32'sd120);
      step(T_O, '0, 1'b0, 1'b1, "rep_third");
      check("rep_third_pred", 32'(prediction), 32'sd120);

      // Walk the track up to x_pred = 32000, v_pred = 1000, then saturate.
      apply_reset(T_N);
      full_seq(16'sd28000, 16'sd28000, "ramp0");
      full_seq(16'sd32000, 16'sd31000, "ramp1");
      full_seq(16'sd31000, 16'sd32000, "ramp2");
      full_seq(16'sd32767, 16'sd32767, "sat");
      check("sat_x_est", 32'(dut.x_est_q), 32'sd32383);
      check("sat_v_est", 32'(dut.v_est_q), 32'sd1191);

      // Reset wins over a predict strobe arriving in WAIT_PREDICT.
      step(T_L, 16'sd7, 1'b0, 1'b0, "mid_latch");
      step(T_U, '0,     1'b0, 1'b0, "mid_update");
      apply_reset(T_P);
      full_seq(-16'sd50, -16'sd50, "neg");

      // r = -3: floor shifts give x_est = -52, v_est = -1, prediction = -53.
      full_seq(-16'sd53, -16'sd53, "floor");
      check("floor_x_est", 32'(dut.x_est_q), -32'sd52);
      check("floor_v_est", 32'(dut.v_est_q), -32'sd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alpha_beta_predictor
